// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the writeback slice.
//   REG_AW / REG_DW : default register-number and data widths
//   R0              : the hard-wired zero register; writes to it are no-ops
//   wb_req          : one register-file write request (enable, number, data)
// ----------------------------------------------------------------------------
package cpu_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] R0 = '0;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] wn;
        logic [REG_DW-1:0] d;
    } wb_req;
endpackage

// File: rtl/wb_pend_buf.sv
// ----------------------------------------------------------------------------
// wb_pend_buf
// One-entry holding register for a writeback result waiting for a free slot.
// Ports:
//   clk, clrn       clock, synchronous active-high reset
//   load            capture ld_wn/ld_d and mark the entry valid
//   clear           release the entry (drained or discarded)
//   ld_wn, ld_d     entry to capture
//   pend_v          entry valid
//   pend_wn, pend_d held register number and data
//   ready           registered !pend_v, safe to use as an upstream ready
// ----------------------------------------------------------------------------
module wb_pend_buf
    import cpu_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] ld_wn,
    input  logic [DW-1:0] ld_d,
    output logic          pend_v,
    output logic [AW-1:0] pend_wn,
    output logic [DW-1:0] pend_d,
    output logic          ready
);

    // ready is kept as its own flop carrying !pend_v so upstream sees a
    // registered signal with no path back from lq_valid.
    always_ff @(posedge clk) begin
        if (clrn) begin
            pend_v <= 1'b0;
            ready  <= 1'b1;
        end else if (load) begin
            pend_v <= 1'b1;
            ready  <= 1'b0;
        end else if (clear) begin
            pend_v <= 1'b0;
            ready  <= 1'b1;
        end
    end

    // Contents are only meaningful while pend_v is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            pend_wn <= ld_wn;
            pend_d  <= ld_d;
        end
    end

endmodule

// File: rtl/wb_merge2w.sv
// ----------------------------------------------------------------------------
// wb_merge2w
// Dual-issue writeback stage feeding a two-write-port register file.
// Registers the x (older) and y (younger) pipe results and merges one
// buffered long-latency result into whichever write slot is idle.
// Optional feature: define WB_PERF_EN to add perf_hold / perf_drop counters.
// Ports:
//   clk, clrn                 clock, synchronous active-high reset
//   mx_we, mx_wn, mx_d        pipe x result
//   my_we, my_wn, my_d        pipe y result
//   lq_valid, lq_wn, lq_d     long-latency result offer
//   lq_ready                  registered accept-ready for the long-latency unit
//   wex, wnx, dx              register-file x write port
//   wey, wny, dy              register-file y write port
//   perf_hold, perf_drop      (WB_PERF_EN only) saturating event counters
// ----------------------------------------------------------------------------
module wb_merge2w
    import cpu_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          mx_we,
    input  logic [AW-1:0] mx_wn,
    input  logic [DW-1:0] mx_d,
    input  logic          my_we,
    input  logic [AW-1:0] my_wn,
    input  logic [DW-1:0] my_d,
    input  logic          lq_valid,
    input  logic [AW-1:0] lq_wn,
    input  logic [DW-1:0] lq_d,
    output logic          lq_ready,
    output logic          wex,
    output logic [AW-1:0] wnx,
    output logic [DW-1:0] dx,
    output logic          wey,
    output logic [AW-1:0] wny,
    output logic [DW-1:0] dy
`ifdef WB_PERF_EN
    ,
    output logic [31:0]   perf_hold,
    output logic [31:0]   perf_drop
`endif
);

    localparam logic [AW-1:0] RZ = AW'(R0);

    logic          pend_v;
    logic [AW-1:0] pend_wn;
    logic [DW-1:0] pend_d;
    logic          x_busy, y_busy;
    logic          drop, to_x, to_y, hold;
    logic          load;

    // A write to r0 does nothing, so such a slot counts as free.
    assign x_busy = mx_we && (mx_wn != RZ);
    assign y_busy = my_we && (my_wn != RZ);

    // A pipe write to the same register is younger than the pending result,
    // so the pending one is dropped rather than written and then overwritten.
    always_comb begin
        drop = 1'b0;
        to_y = 1'b0;
        to_x = 1'b0;
        hold = 1'b0;
        if (pend_v) begin
            if ((pend_wn == RZ) ||
                (x_busy && (pend_wn == mx_wn)) ||
                (y_busy && (pend_wn == my_wn)))
                drop = 1'b1;
            else if (!y_busy)
                to_y = 1'b1;
            else if (!x_busy)
                to_x = 1'b1;
            else
                hold = 1'b1;
        end
    end

    // lq_ready is low whenever an entry is held, so load and clear are
    // mutually exclusive.
    assign load = lq_valid && lq_ready;

    wb_pend_buf #(.AW(AW), .DW(DW)) u_pend (
        .clk     (clk),
        .clrn    (clrn),
        .load    (load),
        .clear   (drop || to_x || to_y),
        .ld_wn   (lq_wn),
        .ld_d    (lq_d),
        .pend_v  (pend_v),
        .pend_wn (pend_wn),
        .pend_d  (pend_d),
        .ready   (lq_ready)
    );

    // MEM -> register-file write ports
    always_ff @(posedge clk) begin
        if (clrn) begin
            wex <= 1'b0;
            wnx <= '0;
            dx  <= '0;
            wey <= 1'b0;
            wny <= '0;
            dy  <= '0;
        end else begin
            wex <= x_busy || to_x;
            wnx <= to_x ? pend_wn : mx_wn;
            dx  <= to_x ? pend_d  : mx_d;
            wey <= y_busy || to_y;
            wny <= to_y ? pend_wn : my_wn;
            dy  <= to_y ? pend_d  : my_d;
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk) begin
        if (clrn) begin
            perf_hold <= '0;
            perf_drop <= '0;
        end else begin
            if (hold && (perf_hold != '1))
                perf_hold <= perf_hold + 32'd1;
            if (drop && (perf_drop != '1))
                perf_drop <= perf_drop + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_merge2w.sv
module tb_wb_merge2w;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clrn;
    logic          mx_we, my_we, lq_valid;
    logic [AW-1:0] mx_wn, my_wn, lq_wn;
    logic [DW-1:0] mx_d, my_d, lq_d;
    logic          lq_ready, wex, wey;
    logic [AW-1:0] wnx, wny;
    logic [DW-1:0] dx, dy;
`ifdef WB_PERF_EN
    logic [31:0]   perf_hold, perf_drop;
`endif

    wb_merge2w #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .mx_we    (mx_we),
        .mx_wn    (mx_wn),
        .mx_d     (mx_d),
        .my_we    (my_we),
        .my_wn    (my_wn),
        .my_d     (my_d),
        .lq_valid (lq_valid),
        .lq_wn    (lq_wn),
        .lq_d     (lq_d),
        .lq_ready (lq_ready),
        .wex      (wex),
        .wnx      (wnx),
        .dx       (dx),
        .wey      (wey),
        .wny      (wny),
        .dy       (dy)
`ifdef WB_PERF_EN
        ,
        .perf_hold(perf_hold),
        .perf_drop(perf_drop)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wex;
        logic [AW-1:0] wnx;
        logic [DW-1:0] dx;
        logic          wey;
        logic [AW-1:0] wny;
        logic [DW-1:0] dy;
        logic          rdy;
        logic [31:0]   hold;
        logic [31:0]   drop;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // reference state of the stage
    logic          m_pv;
    logic [AW-1:0] m_pwn;
    logic [DW-1:0] m_pd;
    logic          m_rdy;
    logic [31:0]   m_hold, m_drop;

    // Scoreboard consumer: every edge that a step pushed for is checked here.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic ok;
            e  = sbq.pop_front();
            ok = (wex === e.wex) && (wey === e.wey) && (lq_ready === e.rdy);
            if (e.wex) ok = ok && (wnx === e.wnx) && (dx === e.dx);
            if (e.wey) ok = ok && (wny === e.wny) && (dy === e.dy);
`ifdef WB_PERF_EN
            ok = ok && (perf_hold === e.hold) && (perf_drop === e.drop);
`endif
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL sb t=%0t got x=%b/%0d/%h y=%b/%0d/%h rdy=%b want x=%b/%0d/%h y=%b/%0d/%h rdy=%b",
                         $time, wex, wnx, dx, wey, wny, dy, lq_ready,
                         e.wex, e.wnx, e.dx, e.wey, e.wny, e.dy, e.rdy);
            end
        end
    end

    // Build the expectation from the current inputs, clock once, then queue it.
    task automatic step(input bit rst);
        exp_t e;
        logic xe, ye, drp, tx, ty, hld, acc;
        xe  = mx_we && (mx_wn != 0);
        ye  = my_we && (my_wn != 0);
        drp = 0; tx = 0; ty = 0; hld = 0;
        e.hold = m_hold; e.drop = m_drop;
        if (rst) begin
            e.wex = 0; e.wnx = 0; e.dx = 0;
            e.wey = 0; e.wny = 0; e.dy = 0;
            e.rdy = 1; e.hold = 0; e.drop = 0;
            m_pv = 0;
        end else begin
            if (m_pv) begin
                if (m_pwn == 0 || (xe && m_pwn == mx_wn) || (ye && m_pwn == my_wn)) drp = 1;
                else if (!ye) ty = 1;
                else if (!xe) tx = 1;
                else hld = 1;
            end
            e.wex = xe || tx; e.wnx = tx ? m_pwn : mx_wn; e.dx = tx ? m_pd : mx_d;
            e.wey = ye || ty; e.wny = ty ? m_pwn : my_wn; e.dy = ty ? m_pd : my_d;
            if (hld && e.hold != 32'hFFFF_FFFF) e.hold = e.hold + 1;
            if (drp && e.drop != 32'hFFFF_FFFF) e.drop = e.drop + 1;
            acc = lq_valid && m_rdy;
            if (acc) begin
                m_pv = 1; m_pwn = lq_wn; m_pd = lq_d;
            end else if (!hld) begin
                m_pv = 0;
            end
            e.rdy = !m_pv;
        end
        m_rdy  = e.rdy;
        m_hold = e.hold;
        m_drop = e.drop;
        clrn   = rst;
        @(posedge clk);
        sbq.push_back(e);
        #1;
        clrn = 0;
    endtask

    task automatic idle_inputs();
        mx_we = 0; mx_wn = 0; mx_d = 0;
        my_we = 0; my_wn = 0; my_d = 0;
        lq_valid = 0; lq_wn = 0; lq_d = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        m_rdy = 1; m_pv = 0; m_pwn = 0; m_pd = 0; m_hold = 0; m_drop = 0;
        step(1);
        total++;
        if (wex !== 0 || wey !== 0 || wnx !== 0 || wny !== 0 || dx !== 0 || dy !== 0 || lq_ready !== 1) begin
            bad++;
            $display("FAIL reset got wex=%b wey=%b wnx=%0d wny=%0d dx=%h dy=%h rdy=%b want all 0, rdy=1",
                     wex, wey, wnx, wny, dx, dy, lq_ready);
        end
    endtask

    task automatic test_pipe();
        mx_we = 1; mx_wn = 3; mx_d = 32'h11;
        my_we = 1; my_wn = 4; my_d = 32'h22;
        step(0);
        total++;
        if (wex !== 1 || wnx !== 3 || dx !== 32'h11 || wey !== 1 || wny !== 4 || dy !== 32'h22 || lq_ready !== 1) begin
            bad++;
            $display("FAIL pipe got x=%b/%0d/%h y=%b/%0d/%h rdy=%b want x=1/3/11 y=1/4/22 rdy=1",
                     wex, wnx, dx, wey, wny, dy, lq_ready);
        end
    endtask

    task automatic test_r0();
        idle_inputs();
        mx_we = 1; mx_wn = 0; mx_d = 32'h55;
        step(0);
        total++;
        if (wex !== 0 || wey !== 0) begin
            bad++;
            $display("FAIL r0 got wex=%b wey=%b want 0 0", wex, wey);
        end
    endtask

    task automatic test_lq_drain();
        idle_inputs();
        lq_valid = 1; lq_wn = 7; lq_d = 32'hABCD;
        step(0);
        lq_valid = 0;
        total++;
        if (lq_ready !== 0) begin
            bad++;
            $display("FAIL lq_accept got rdy=%b want 0", lq_ready);
        end
        step(0);
        total++;
        if (wey !== 1 || wny !== 7 || dy !== 32'hABCD || wex !== 0 || lq_ready !== 1) begin
            bad++;
            $display("FAIL lq_drain got y=%b/%0d/%h wex=%b rdy=%b want y=1/7/abcd wex=0 rdy=1",
                     wey, wny, dy, wex, lq_ready);
        end
    endtask

    task automatic test_hold();
        idle_inputs();
        step(1);
        lq_valid = 1; lq_wn = 9; lq_d = 32'h9999;
        step(0);
        lq_valid = 0;
        mx_we = 1; mx_wn = 1; mx_d = 32'h101;
        my_we = 1; my_wn = 2; my_d = 32'h202;
        for (int i = 0; i < 3; i++) begin
            step(0);
            total++;
            if (lq_ready !== 0 || wny !== 2 || wnx !== 1) begin
                bad++;
                $display("FAIL hold[%0d] got rdy=%b wnx=%0d wny=%0d want rdy=0 wnx=1 wny=2", i, lq_ready, wnx, wny);
            end
        end
`ifdef WB_PERF_EN
        total++;
        if (perf_hold !== 32'd3) begin
            bad++;
            $display("FAIL perf_hold got %0d want 3", perf_hold);
        end
`endif
        my_we = 0;
        step(0);
        total++;
        if (wey !== 1 || wny !== 9 || dy !== 32'h9999 || wex !== 1 || wnx !== 1 || lq_ready !== 1) begin
            bad++;
            $display("FAIL hold_drain got x=%b/%0d y=%b/%0d/%h rdy=%b want x=1/1 y=1/9/9999 rdy=1",
                     wex, wnx, wey, wny, dy, lq_ready);
        end
    endtask

    task automatic test_collide();
        idle_inputs();
        step(1);
        lq_valid = 1; lq_wn = 5; lq_d = 32'h5555;
        step(0);
        lq_valid = 0;
        mx_we = 1; mx_wn = 5; mx_d = 32'h77;
        step(0);
        total++;
        if (wex !== 1 || wnx !== 5 || dx !== 32'h77 || wey !== 0 || lq_ready !== 1) begin
            bad++;
            $display("FAIL collide got x=%b/%0d/%h wey=%b rdy=%b want x=1/5/77 wey=0 rdy=1",
                     wex, wnx, dx, wey, lq_ready);
        end
`ifdef WB_PERF_EN
        total++;
        if (perf_drop !== 32'd1) begin
            bad++;
            $display("FAIL perf_drop got %0d want 1", perf_drop);
        end
`endif
    endtask

    task automatic test_reset_pend();
        idle_inputs();
        lq_valid = 1; lq_wn = 6; lq_d = 32'h6666;
        step(0);
        lq_wn = 8; lq_d = 32'h8888;
        step(1);
        total++;
        if (wex !== 0 || wey !== 0 || lq_ready !== 1) begin
            bad++;
            $display("FAIL reset_pend got wex=%b wey=%b rdy=%b want 0 0 1", wex, wey, lq_ready);
        end
        lq_valid = 0;
        step(0);
        total++;
        if (wey !== 0 || wex !== 0 || lq_ready !== 1) begin
            bad++;
            $display("FAIL reset_lost got wex=%b wey=%b rdy=%b want 0 0 1", wex, wey, lq_ready);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            mx_we    = $urandom_range(0, 3) != 0;
            mx_wn    = AW'($urandom_range(0, 7));
            mx_d     = $urandom;
            my_we    = $urandom_range(0, 3) != 0;
            my_wn    = AW'($urandom_range(0, 7));
            my_d     = $urandom;
            lq_valid = $urandom_range(0, 1) != 0;
            lq_wn    = AW'($urandom_range(0, 7));
            lq_d     = $urandom;
            step((i % 97) == 96);
        end
        idle_inputs();
        step(0);
        step(0);
    endtask

    initial begin
        clrn = 1;
        idle_inputs();
        test_reset();
        test_pipe();
        test_r0();
        test_lq_drain();
        test_hold();
        test_collide();
        test_reset_pend();
        test_back_to_back();
        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got %0d left want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
